// File: rtl/sum_collect_pkg.sv
// Shared definitions for the sum_collect burst accumulator.
package sum_collect_pkg;

    // Default geometry: samples per full burst and width of one sample.
    localparam int unsigned DEF_BURST_LEN = 8;
    localparam int unsigned DEF_IN_W      = 5;

    // Width of the sample-count output (covers 1..16 samples).
    localparam int unsigned CNT_W = 5;

    // Collector states: nothing held, partial burst held, result presented.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Total width that holds BURST_LEN full-scale samples without overflow.
    function automatic int unsigned acc_width(input int unsigned in_w,
                                              input int unsigned burst_len);
        return in_w + $clog2(burst_len);
    endfunction

endpackage

// File: rtl/sum_collect_if.sv
// Sample-in / result-out handshake bundle for sum_collect.
interface sum_collect_if
    import sum_collect_pkg::*;
#(
    parameter int unsigned IN_W      = DEF_IN_W,
    parameter int unsigned BURST_LEN = DEF_BURST_LEN
) ();

    localparam int unsigned ACC_W = acc_width(IN_W, BURST_LEN);

    // Upstream sample stream
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;

    // Downstream burst result
    logic [ACC_W-1:0] out_sum;
    logic [IN_W-1:0]  out_max;
    logic [CNT_W-1:0] out_count;
    logic             out_valid;
    logic             out_ready;

    // Producer of samples and consumer of results
    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_sum, out_max, out_count, out_valid
    );

    // The collector itself
    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_sum, out_max, out_count, out_valid
    );

endinterface

// File: rtl/sum_collect.sv
// Collects a burst of sum samples and presents total, maximum and count.
module sum_collect
    import sum_collect_pkg::*;
#(
    parameter int unsigned BURST_LEN = DEF_BURST_LEN,
    parameter int unsigned IN_W      = DEF_IN_W
) (
    input  logic         clk,
    input  logic         rst,
    sum_collect_if.slave bus
);

    localparam int unsigned      ACC_W    = acc_width(IN_W, BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [IN_W-1:0]  max_q;
    logic [CNT_W-1:0] cnt;

    logic [ACC_W-1:0] acc_nxt;
    logic [IN_W-1:0]  max_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             burst_done;

    // Running totals after accepting the current sample; IDLE starts a fresh burst.
    always_comb begin
        acc_nxt = ACC_W'(bus.in_data);
        max_nxt = bus.in_data;
        cnt_nxt = CNT_W'(1);
        if (state == ACCUM) begin
            acc_nxt = acc + ACC_W'(bus.in_data);
            max_nxt = (bus.in_data > max_q) ? bus.in_data : max_q;
            cnt_nxt = cnt + CNT_W'(1);
        end
        burst_done = bus.in_last || (cnt_nxt == LAST_CNT);
    end

    // Burst FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            acc           <= '0;
            max_q         <= '0;
            cnt           <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_max   <= '0;
            bus.out_count <= '0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (bus.in_valid) begin
                        acc   <= acc_nxt;
                        max_q <= max_nxt;
                        cnt   <= cnt_nxt;
                        if (burst_done) begin
                            state         <= HOLD;
                            bus.in_ready  <= 1'b0;
                            bus.out_valid <= 1'b1;
                            bus.out_sum   <= acc_nxt;
                            bus.out_max   <= max_nxt;
                            bus.out_count <= cnt_nxt;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.in_ready  <= 1'b1;
                        bus.out_valid <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.in_ready  <= 1'b1;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
